// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit processor: flow-operation and fault encodings
// plus the program-counter sequencer's state type.
package cpu_pkg;

    localparam logic [2:0] PC_INC  = 3'd0;
    localparam logic [2:0] PC_JMP  = 3'd1;
    localparam logic [2:0] PC_CALL = 3'd2;
    localparam logic [2:0] PC_RET  = 3'd3;
    localparam logic [2:0] PC_GOTO = 3'd4;
    localparam logic [2:0] PC_JZ   = 3'd5;
    localparam logic [2:0] PC_JNZ  = 3'd6;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_OVF  = 2'd1;
    localparam logic [1:0] ERR_UNF  = 2'd2;
    localparam logic [1:0] ERR_ILL  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

endpackage

// File: rtl/ret_stack.sv
// Return-address stack: DEPTH x W register array with push/pop and occupancy.
// The array itself is never reset; only the occupancy counter is.
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             push_data,
    output logic [W-1:0]             top_data,
    output logic [$clog2(DEPTH):0]   sp,
    output logic                     full,
    output logic                     empty
);

    localparam int AW   = $clog2(DEPTH);
    localparam int SP_W = AW + 1;

    logic [W-1:0]    mem_q [DEPTH];
    logic [SP_W-1:0] sp_q;
    logic [SP_W-1:0] sp_d;

    assign full     = (sp_q == SP_W'(DEPTH));
    assign empty    = (sp_q == '0);
    assign sp       = sp_q;
    assign top_data = mem_q[AW'(sp_q - 1'b1)];

    always_comb begin
        sp_d = sp_q;
        if (push && !full) begin
            sp_d = sp_q + 1'b1;
        end else if (pop && !empty) begin
            sp_d = sp_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !full) begin
            mem_q[AW'(sp_q)] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: executes one flow operation per two-cycle handshake,
// owns the return-address stack and latches stack/opcode faults until cleared.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_PC    = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          op_valid,
    input  logic [2:0]                    op_code,
    input  logic [PC_W-1:0]               target,
    input  logic                          zero_flag,
    input  logic                          clear_err,
    output logic                          op_ready,
    output logic                          done,
    output logic [PC_W-1:0]               pc,
    output logic [$clog2(STACK_DEPTH):0]  sp,
    output logic                          err,
    output logic [1:0]                    err_code
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] target_q, target_d;
    logic [2:0]      op_code_q, op_code_d;
    logic            zero_q, zero_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [1:0]      err_code_q, err_code_d;
    logic            op_ready_q, op_ready_d;

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] next_pc;
    logic [PC_W-1:0] stk_top;
    logic [1:0]      fault_code;
    logic            push, pop;
    logic            stk_full, stk_empty;

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_W)
    ) u_ret_stack (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top_data  (stk_top),
        .sp        (sp),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // JMP adds the raw target: modulo 2^PC_W this equals adding the sign-extended offset.
    always_comb begin
        pc_inc     = pc_q + 1'b1;
        next_pc    = pc_inc;
        fault_code = ERR_NONE;
        case (op_code_q)
            PC_INC:  next_pc = pc_inc;
            PC_JMP:  next_pc = pc_q + target_q;
            PC_CALL: begin
                next_pc = target_q;
                if (stk_full) fault_code = ERR_OVF;
            end
            PC_RET: begin
                next_pc = stk_top;
                if (stk_empty) fault_code = ERR_UNF;
            end
            PC_GOTO: next_pc = target_q;
            PC_JZ:   next_pc = zero_q ? target_q : pc_inc;
            PC_JNZ:  next_pc = zero_q ? pc_inc : target_q;
            default: fault_code = ERR_ILL;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        target_d   = target_q;
        op_code_d  = op_code_q;
        zero_d     = zero_q;
        done_d     = 1'b0;
        err_d      = err_q;
        err_code_d = err_code_q;
        op_ready_d = op_ready_q;
        push       = 1'b0;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    op_code_d  = op_code;
                    target_d   = target;
                    zero_d     = zero_flag;
                    op_ready_d = 1'b0;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (fault_code != ERR_NONE) begin
                    err_d      = 1'b1;
                    err_code_d = fault_code;
                    state_d    = ST_ERROR;
                end else begin
                    pc_d       = next_pc;
                    done_d     = 1'b1;
                    op_ready_d = 1'b1;
                    push       = (op_code_q == PC_CALL);
                    pop        = (op_code_q == PC_RET);
                    state_d    = ST_IDLE;
                end
            end
            ST_ERROR: begin
                if (clear_err) begin
                    err_d      = 1'b0;
                    err_code_d = ERR_NONE;
                    op_ready_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                op_ready_d = 1'b1;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= PC_W'(RESET_PC);
            target_q   <= '0;
            op_code_q  <= PC_INC;
            zero_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            op_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            target_q   <= target_d;
            op_code_q  <= op_code_d;
            zero_q     <= zero_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            op_ready_q <= op_ready_d;
        end
    end

    assign pc       = pc_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign op_ready = op_ready_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations, then
// randomized operations compared every cycle against a queue-based model.
module tb_pc_sequencer;

    localparam int PC_W     = 8;
    localparam int DEPTH    = 4;
    localparam int RESET_PC = 0;
    localparam int MOD      = 1 << PC_W;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             op_valid = 1'b0;
    logic [2:0]       op_code = 3'd0;
    logic [PC_W-1:0]  target = '0;
    logic             zero_flag = 1'b0;
    logic             clear_err = 1'b0;
    logic             op_ready;
    logic             done;
    logic [PC_W-1:0]  pc;
    logic [2:0]       sp;
    logic             err;
    logic [1:0]       err_code;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(
        .PC_W        (PC_W),
        .STACK_DEPTH (DEPTH),
        .RESET_PC    (RESET_PC)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .op_valid  (op_valid),
        .op_code   (op_code),
        .target    (target),
        .zero_flag (zero_flag),
        .clear_err (clear_err),
        .op_ready  (op_ready),
        .done      (done),
        .pc        (pc),
        .sp        (sp),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clock = ~clock;

    // Reference model: pc as an integer, the stack as a queue of return addresses.
    int  m_pc;
    int  m_stack[$];
    bit  m_pend, m_in_err, m_done, m_err;
    int  m_code;
    int  p_op, p_tgt;
    bit  p_zf;

    task automatic modelExecute();
        int fault;
        int off;
        fault = 0;
        case (p_op)
            0: m_pc = (m_pc + 1) % MOD;
            1: begin
                off  = (p_tgt >= MOD / 2) ? p_tgt - MOD : p_tgt;
                m_pc = (m_pc + off + MOD) % MOD;
            end
            2: begin
                if (m_stack.size() == DEPTH) fault = 1;
                else begin
                    m_stack.push_back((m_pc + 1) % MOD);
                    m_pc = p_tgt;
                end
            end
            3: begin
                if (m_stack.size() == 0) fault = 2;
                else m_pc = m_stack.pop_back();
            end
            4: m_pc = p_tgt;
            5: m_pc = p_zf ? p_tgt : (m_pc + 1) % MOD;
            6: m_pc = p_zf ? (m_pc + 1) % MOD : p_tgt;
            default: fault = 3;
        endcase
        if (fault != 0) begin
            m_err    = 1'b1;
            m_code   = fault;
            m_in_err = 1'b1;
        end else begin
            m_done = 1'b1;
        end
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_pc = RESET_PC;
            m_stack.delete();
            m_pend   = 1'b0;
            m_in_err = 1'b0;
            m_done   = 1'b0;
            m_err    = 1'b0;
            m_code   = 0;
        end else begin
            m_done = 1'b0;
            if (m_pend) begin
                m_pend = 1'b0;
                modelExecute();
            end else if (m_in_err) begin
                if (clear_err) begin
                    m_in_err = 1'b0;
                    m_err    = 1'b0;
                    m_code   = 0;
                end
            end else if (op_valid) begin
                m_pend = 1'b1;
                p_op   = int'(op_code);
                p_tgt  = int'(target);
                p_zf   = zero_flag;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            checkOutput("model_pc",       32'(pc),       32'(m_pc));
            checkOutput("model_sp",       32'(sp),       32'(m_stack.size()));
            checkOutput("model_op_ready", 32'(op_ready), 32'(!m_pend && !m_in_err));
            checkOutput("model_done",     32'(done),     32'(m_done));
            checkOutput("model_err",      32'(err),      32'(m_err));
            checkOutput("model_err_code", 32'(err_code), 32'(m_code));
        end
    end

    // Called and returning at a falling edge; returns after the commit edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [PC_W-1:0] tgt,
                                 input logic zf, input bit flip_zf);
        int wait_cycles;
        wait_cycles = 0;
        while (op_ready !== 1'b1 && wait_cycles < 20) begin
            @(negedge clock);
            wait_cycles++;
        end
        if (op_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL op_ready_timeout: got op_ready=%b required 1 within 20 cycles", op_ready);
            return;
        end
        op_valid  = 1'b1;
        op_code   = op;
        target    = tgt;
        zero_flag = zf;
        @(negedge clock);
        op_valid  = 1'($urandom_range(0, 1));
        clear_err = 1'($urandom_range(0, 1));
        op_code   = 3'($urandom);
        target    = PC_W'($urandom);
        zero_flag = flip_zf ? ~zf : zf;
        @(negedge clock);
        op_valid  = 1'b0;
        clear_err = 1'b0;
    endtask

    task automatic clearError();
        clear_err = 1'b1;
        op_valid  = 1'b1;
        op_code   = 3'd0;
        @(negedge clock);
        clear_err = 1'b0;
        op_valid  = 1'b0;
    endtask

    initial begin
        int r;
        logic [2:0] op;
        $display("[TB] start");
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        @(negedge clock);

        checkOutput("rst_pc", 32'(pc), 32'h00);
        checkOutput("rst_sp", 32'(sp), 32'h0);
        checkOutput("rst_op_ready", 32'(op_ready), 32'h1);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_err", 32'(err), 32'h0);
        checkOutput("rst_err_code", 32'(err_code), 32'h0);

        applyStimulus(3'd0, 8'h00, 1'b0, 1'b0);
        checkOutput("inc1_pc", 32'(pc), 32'h01);
        checkOutput("inc1_done", 32'(done), 32'h1);
        applyStimulus(3'd0, 8'h00, 1'b0, 1'b0);
        checkOutput("inc2_pc", 32'(pc), 32'h02);
        applyStimulus(3'd0, 8'h00, 1'b0, 1'b0);
        checkOutput("inc3_pc", 32'(pc), 32'h03);
        @(negedge clock);
        checkOutput("done_single_pulse", 32'(done), 32'h0);

        applyStimulus(3'd4, 8'h10, 1'b0, 1'b0);
        applyStimulus(3'd1, 8'hFC, 1'b0, 1'b0);
        checkOutput("jmp_back_pc", 32'(pc), 32'h0C);
        applyStimulus(3'd4, 8'hFF, 1'b0, 1'b0);
        applyStimulus(3'd0, 8'h00, 1'b0, 1'b0);
        checkOutput("inc_wrap_pc", 32'(pc), 32'h00);
        checkOutput("inc_wrap_err", 32'(err), 32'h0);

        applyStimulus(3'd4, 8'h20, 1'b0, 1'b0);
        applyStimulus(3'd5, 8'h40, 1'b1, 1'b1);
        checkOutput("jz_taken_pc", 32'(pc), 32'h40);
        applyStimulus(3'd4, 8'h20, 1'b0, 1'b0);
        applyStimulus(3'd6, 8'h40, 1'b1, 1'b0);
        checkOutput("jnz_not_taken_pc", 32'(pc), 32'h21);

        applyStimulus(3'd4, 8'h05, 1'b0, 1'b0);
        applyStimulus(3'd2, 8'h50, 1'b0, 1'b0);
        applyStimulus(3'd2, 8'h60, 1'b0, 1'b0);
        checkOutput("call2_sp", 32'(sp), 32'h2);
        checkOutput("call2_pc", 32'(pc), 32'h60);
        applyStimulus(3'd3, 8'h00, 1'b0, 1'b0);
        checkOutput("ret1_pc", 32'(pc), 32'h51);
        applyStimulus(3'd3, 8'h00, 1'b0, 1'b0);
        checkOutput("ret2_pc", 32'(pc), 32'h06);
        checkOutput("ret2_sp", 32'(sp), 32'h0);

        for (int i = 0; i < 4; i++) applyStimulus(3'd2, 8'(8'h70 + i), 1'b0, 1'b0);
        checkOutput("call_fill_sp", 32'(sp), 32'h4);
        applyStimulus(3'd2, 8'h80, 1'b0, 1'b0);
        checkOutput("ovf_err", 32'(err), 32'h1);
        checkOutput("ovf_code", 32'(err_code), 32'h1);
        checkOutput("ovf_pc", 32'(pc), 32'h73);
        checkOutput("ovf_sp", 32'(sp), 32'h4);
        checkOutput("ovf_done", 32'(done), 32'h0);
        checkOutput("ovf_op_ready", 32'(op_ready), 32'h0);
        clearError();
        checkOutput("clr_err", 32'(err), 32'h0);
        checkOutput("clr_op_ready", 32'(op_ready), 32'h1);
        checkOutput("clr_op_ignored_pc", 32'(pc), 32'h73);

        for (int i = 0; i < 4; i++) applyStimulus(3'd3, 8'h00, 1'b0, 1'b0);
        checkOutput("unwind_pc", 32'(pc), 32'h07);
        applyStimulus(3'd3, 8'h00, 1'b0, 1'b0);
        checkOutput("unf_code", 32'(err_code), 32'h2);
        checkOutput("unf_pc", 32'(pc), 32'h07);
        clearError();
        applyStimulus(3'd7, 8'h00, 1'b0, 1'b0);
        checkOutput("ill_code", 32'(err_code), 32'h3);
        clearError();

        applyStimulus(3'd2, 8'h90, 1'b0, 1'b0);
        op_valid = 1'b1;
        op_code  = 3'd2;
        target   = 8'hA0;
        @(negedge clock);
        op_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_exec_pc", 32'(pc), 32'h00);
        checkOutput("rst_exec_sp", 32'(sp), 32'h0);
        checkOutput("rst_exec_done", 32'(done), 32'h0);
        @(negedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        checkOutput("post_rst_pc", 32'(pc), 32'h00);
        checkOutput("post_rst_done", 32'(done), 32'h0);

        for (int n = 0; n < 300; n++) begin
            if (m_in_err) begin
                clearError();
            end else begin
                repeat ($urandom_range(0, 2)) begin
                    clear_err = 1'($urandom_range(0, 1));
                    @(negedge clock);
                end
                clear_err = 1'b0;
                r = int'($urandom_range(0, 15));
                if (r < 2 || r == 15) op = 3'd0;
                else if (r == 2)      op = 3'd1;
                else if (r < 6)       op = 3'd2;
                else if (r < 9)       op = 3'd3;
                else if (r == 9)      op = 3'd4;
                else if (r < 12)      op = 3'd5;
                else if (r < 14)      op = 3'd6;
                else                  op = 3'd7;
                applyStimulus(op, PC_W'($urandom), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)));
            end
        end
        @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the program counter and a hardware return-address stack for the 8-bit processor. The control unit issues one flow operation per instruction: increment, jump, call, return, goto, jump-if-zero or jump-if-not-zero. The block executes it over a fixed two-cycle handshake and reports stack faults. It sits between the control unit and the instruction-memory address bus.

Parameters:
PC_W, 8, program counter and target width in bits
STACK_DEPTH, 4, number of return-address entries (power of 2, at least 2)
RESET_PC, 0, value loaded into pc on reset

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low
op_valid  input  1  control unit presents an operation
op_code  input  3  flow operation (encoding in package)
target  input  PC_W  absolute address (GOTO/CALL/JZ/JNZ) or signed offset (JMP)
zero_flag  input  1  ALU zero flag, used by JZ/JNZ
clear_err  input  1  clears sticky error state
op_ready  output  1  block can accept an operation this cycle
done  output  1  one-cycle pulse when pc/stack update has committed
pc  output  PC_W  current program counter
sp  output  clog2(STACK_DEPTH)+1  stack occupancy, 0..STACK_DEPTH
err  output  1  sticky fault flag
err_code  output  2  0 none, 1 overflow, 2 underflow, 3 illegal opcode

Behaviour:
- Reset is asynchronous, active-low; the clock is clock. Reset values: pc=RESET_PC, sp=0, op_ready=1, done=0, err=0, err_code=0, state=IDLE. Stack RAM contents are not cleared.
- FSM states: IDLE, EXEC, ERROR.
- IDLE: op_ready=1. Accept when op_valid=1. Register op_code, target and zero_flag at acceptance; later changes to zero_flag have no effect. Go to EXEC.
- EXEC: op_ready=0. Commit the update at the end of this cycle. done=1 for this single cycle. Return to IDLE, or go to ERROR on a fault.
- Latency: op accepted on edge N; new pc and done visible after edge N+1. Back-to-back issue gives at most one op per 2 cycles.
- Operations (all pc arithmetic is modulo 2^PC_W and wraps silently):
  - INC: pc <= pc+1.
  - JMP: pc <= pc + sign-extended target.
  - GOTO: pc <= target.
  - JZ: pc <= target if zero_flag=1, else pc+1.
  - JNZ: pc <= target if zero_flag=0, else pc+1.
  - CALL: stack[sp] <= pc+1; sp <= sp+1; pc <= target.
  - RET: sp <= sp-1; pc <= stack[sp-1].
  - Opcode 7 is reserved and treated as illegal.
- Faults are detected in EXEC. On a fault, pc and sp are unchanged, done=0, err=1 and err_code is set. Next state is ERROR.
  - CALL with sp==STACK_DEPTH: overflow, err_code=1.
  - RET with sp==0: underflow, err_code=2.
  - Illegal opcode: err_code=3.
- ERROR: op_ready=0 and op_valid is ignored. clear_err=1 sets err=0 and err_code=0, and the state goes to IDLE on the next edge. An op presented in the same cycle as clear_err is not accepted.
- clear_err in IDLE or EXEC has no effect.
- A CALL that fills the stack (sp becomes STACK_DEPTH) is legal. A RET that empties it (sp becomes 0) is legal.
- Reset asserted mid-EXEC aborts the operation: no commit, no done, all outputs return to reset values.

Decomposition:
- Shared package cpu_pkg holds:
  - op_code localparams: PC_INC=0, PC_JMP=1, PC_CALL=2, PC_RET=3, PC_GOTO=4, PC_JZ=5, PC_JNZ=6.
  - err_code localparams: ERR_NONE=0, ERR_OVF=1, ERR_UNF=2, ERR_ILL=3.
  - FSM state encoding.
- One sub-module, ret_stack: a STACK_DEPTH x PC_W register array with push/pop, sp, full and empty. The top level keeps the FSM, pc register and next-pc mux.

Test Plan:
- Reset, then INC x3 with 2-cycle spacing -> pc=1,2,3; done pulses once per op; op_ready low only in EXEC cycles.
- pc=0x10, JMP target=0xFC (-4) -> pc=0x0C. pc=0xFF, INC -> pc=0x00 (wrap), err=0.
- pc=0x20, JZ target=0x40 with zero_flag=1 at acceptance, dropped to 0 in EXEC -> pc=0x40. JNZ target=0x40 with zero_flag=1 -> pc=0x21.
- Nested calls: CALL 0x50 from pc=0x05, then CALL 0x60 -> sp=2, pc=0x60. RET -> pc=0x51. RET -> pc=0x06, sp=0.
- Five CALLs with STACK_DEPTH=4 -> fifth gives err=1, err_code=1, pc and sp=4 unchanged, no done, op_ready=0. clear_err together with op_valid -> op ignored, IDLE next cycle, err=0.
- RET with sp=0 -> err_code=2. After clear, op_code=7 -> err_code=3. Assert reset during the EXEC of a CALL -> pc=RESET_PC, sp=0, no done pulse.
